decrypt_1block_128a_iter: RTL

- Round-iterative Ascon-128a (v1.2) authenticated decryption of exactly one 16-byte AD block and one 16-byte ciphertext block.
- It is the receive-side counterpart of encrypt_1block_128a, and its outputs must round-trip with that block.
- It holds a single 320-bit state register and one round-function instance, sequenced by an FSM with a round counter.
- It uses a START/BUSY/DONE handshake.
- It sits beside the encrypt core under the Ascon top level, with inputs registered by the top.

---
 rtl/decrypt_1block_128a_iter_if.sv | 24 ++
 rtl/decrypt_1block_128a_iter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_1block_128a_iter_if.sv
// Handshake and data bus for decrypt_1block_128a_iter.
// master: the block that launches a decryption; slave: the decryption core.
interface decrypt_1block_128a_iter_if;
  logic         start;
  logic [127:0] sk;
  logic [127:0] n;
  logic [127:0] a;
  logic [127:0] c;
  logic [127:0] t;
  logic [127:0] p;
  logic         tag_ok;
  logic         done;
  logic         busy;

  modport master (
    output start, sk, n, a, c, t,
    input  p, tag_ok, done, busy
  );

  modport slave (
    input  start, sk, n, a, c, t,
    output p, tag_ok, done, busy
  );
endinterface

// File: rtl/decrypt_1block_128a_iter.sv
// decrypt_1block_128a_iter: round-iterative Ascon-128a authenticated decryption
// of one full 16-byte AD block and one full 16-byte ciphertext block.
// A single 320-bit state register is stepped through the phases
// INIT(PA) -> AD(PB) -> ADPAD(PB) -> CT(PB) -> FIN(PA) -> OUT.
// Optional build macro: ASCON_DEC_UNROLL2_EN (two cascaded rounds per cycle).
module decrypt_1block_128a_iter #(
  parameter int unsigned PA = 12,
  parameter int unsigned PB = 8,
  parameter logic [63:0] IV = 64'h80800c0800000000
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  decrypt_1block_128a_iter_if.slave bus
);

`ifdef ASCON_DEC_UNROLL2_EN
  localparam logic [3:0] STEP = 4'd2;
`else
  localparam logic [3:0] STEP = 4'd1;
`endif
  localparam logic [3:0]   PA_LAST = 4'(PA) - STEP;
  localparam logic [3:0]   PB_LAST = 4'(PB) - STEP;
  // PB rounds reuse the tail of the PA constant schedule
  localparam logic [3:0]   PB_OFS  = 4'(PA - PB);
  localparam logic [127:0] PAD     = {8'h80, 120'd0};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_AD    = 3'd2,
    ST_ADPAD = 3'd3,
    ST_CT    = 3'd4,
    ST_FIN   = 3'd5,
    ST_OUT   = 3'd6
  } state_e;

  // Round constant c_i = 0xf0 - i*0x0f
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return 8'hf0 - ({4'd0, idx} * 8'h0f);
  endfunction

  // One Ascon permutation round: constant addition, bitsliced S-box, linear layer
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, rc};
    x3 = s[127:64];
    x4 = s[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

  state_e       fsm_q;
  logic [3:0]   cnt_q;
  logic [319:0] s_q;
  logic [127:0] sk_q;
  logic [127:0] a_q;
  logic [127:0] c_q;
  logic [127:0] t_q;
  logic [127:0] ptmp_q;
  logic [127:0] tcalc_q;
  logic [127:0] p_q;
  logic         tag_ok_q;
  logic         done_q;
  logic         busy_q;

  logic [3:0]   rc_idx_s;
  logic         last_s;
  state_e       phase_nxt_s;
  logic [319:0] rnd_s;
  logic [319:0] s_d;
  logic         tag_match_s;

  // Constant index: PA phases start at 0, PB phases start at PA-PB
  always_comb begin
    rc_idx_s = cnt_q;
    if ((fsm_q == ST_INIT) || (fsm_q == ST_FIN)) begin
      rc_idx_s = cnt_q;
    end else begin
      rc_idx_s = cnt_q + PB_OFS;
    end
  end

  // Last-round detection and the phase that follows it
  always_comb begin
    last_s      = 1'b0;
    phase_nxt_s = ST_IDLE;
    case (fsm_q)
      ST_INIT:  begin last_s = (cnt_q == PA_LAST); phase_nxt_s = ST_AD;    end
      ST_AD:    begin last_s = (cnt_q == PB_LAST); phase_nxt_s = ST_ADPAD; end
      ST_ADPAD: begin last_s = (cnt_q == PB_LAST); phase_nxt_s = ST_CT;    end
      ST_CT:    begin last_s = (cnt_q == PB_LAST); phase_nxt_s = ST_FIN;   end
      ST_FIN:   begin last_s = (cnt_q == PA_LAST); phase_nxt_s = ST_OUT;   end
      default:  begin last_s = 1'b0;               phase_nxt_s = ST_IDLE;  end
    endcase
  end

`ifdef ASCON_DEC_UNROLL2_EN
  logic [319:0] rnd1_s;

  // Two cascaded rounds per cycle using constants i and i+1
  always_comb begin
    rnd1_s = ascon_round(s_q, round_const(rc_idx_s));
    rnd_s  = ascon_round(rnd1_s, round_const(rc_idx_s + 4'd1));
  end
`else
  // One round per cycle
  always_comb begin
    rnd_s = ascon_round(s_q, round_const(rc_idx_s));
  end
`endif

  // Next state value: round output plus the injection due at the end of each phase
  always_comb begin
    s_d = rnd_s;
    case (fsm_q)
      ST_INIT: begin
        if (last_s) s_d = rnd_s ^ {a_q, 64'd0, sk_q};
        else        s_d = rnd_s;
      end
      ST_AD: begin
        if (last_s) s_d = rnd_s ^ {PAD, 192'd0};
        else        s_d = rnd_s;
      end
      ST_ADPAD: begin
        // domain separation bit, then the rate is replaced by the ciphertext
        if (last_s) s_d = {c_q, rnd_s[191:1], ~rnd_s[0]};
        else        s_d = rnd_s;
      end
      ST_CT: begin
        // empty final plaintext block padding, then key into the capacity
        if (last_s) s_d = rnd_s ^ {PAD, sk_q, 64'd0};
        else        s_d = rnd_s;
      end
      default: s_d = rnd_s;
    endcase
  end

  // Full-width constant-time tag comparison
  always_comb begin
    tag_match_s = ~|(tcalc_q ^ t_q);
  end

  // Control FSM, round counter, state register and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q    <= ST_IDLE;
      cnt_q    <= 4'd0;
      s_q      <= 320'd0;
      sk_q     <= 128'd0;
      a_q      <= 128'd0;
      c_q      <= 128'd0;
      t_q      <= 128'd0;
      ptmp_q   <= 128'd0;
      tcalc_q  <= 128'd0;
      p_q      <= 128'd0;
      tag_ok_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (bus.start) begin
            s_q      <= {IV, bus.sk, bus.n};
            sk_q     <= bus.sk;
            a_q      <= bus.a;
            c_q      <= bus.c;
            t_q      <= bus.t;
            cnt_q    <= 4'd0;
            p_q      <= 128'd0;
            tag_ok_q <= 1'b0;
            busy_q   <= 1'b1;
            fsm_q    <= ST_INIT;
          end else begin
            fsm_q <= ST_IDLE;
          end
        end
        ST_INIT, ST_AD, ST_ADPAD, ST_CT, ST_FIN: begin
          s_q <= s_d;
          if (last_s) begin
            cnt_q <= 4'd0;
            fsm_q <= phase_nxt_s;
          end else begin
            cnt_q <= cnt_q + STEP;
          end
          if ((fsm_q == ST_ADPAD) && last_s) begin
            ptmp_q <= rnd_s[319:192] ^ c_q;
          end
          if ((fsm_q == ST_FIN) && last_s) begin
            tcalc_q <= rnd_s[127:0] ^ sk_q;
          end
        end
        ST_OUT: begin
          // candidate plaintext is released only on a tag match, then scrubbed
          tag_ok_q <= tag_match_s;
          p_q      <= {128{tag_match_s}} & ptmp_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          ptmp_q   <= 128'd0;
          tcalc_q  <= 128'd0;
          fsm_q    <= ST_IDLE;
        end
        default: begin
          fsm_q  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p      = p_q;
  assign bus.tag_ok = tag_ok_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule
